// File: rtl/clock_tick_pkg.sv
// ---------------------------------------------------------------------------
// clock_tick_pkg
// Shared definitions for the multi-channel clock/tick generator.
//   ch_state_t         per-channel FSM state encoding
//   DEFAULT_HALF_CYC   reset half-period (0.5 s at 50 MHz)
//   ch_width()         channel-select width for a given channel count
// ---------------------------------------------------------------------------
package clock_tick_pkg;

  // STOP    : output parked low, counter cleared
  // RUN     : free-running square wave
  // STEP_HI : high phase of a single stepped period
  // STEP_LO : low phase of a single stepped period
  typedef enum logic [1:0] {
    STOP    = 2'd0,
    RUN     = 2'd1,
    STEP_HI = 2'd2,
    STEP_LO = 2'd3
  } ch_state_t;

  // Half-period loaded into every channel on reset.
  localparam int unsigned DEFAULT_HALF_CYC = 25_000_000;

  // A single channel still needs a one-bit select so the bus never
  // collapses to zero width.
  function automatic int ch_width(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

endpackage

// File: rtl/clock_tick_gen_if.sv
// ---------------------------------------------------------------------------
// clock_tick_gen_if
// Half-period configuration channel (valid/ready).
//   cfg_valid  master->slave  update request
//   cfg_ready  slave->master  pending slot free; transfer on valid && ready
//   cfg_ch     master->slave  target channel index
//   cfg_half   master->slave  new half-period in clock cycles (0 disables)
// ---------------------------------------------------------------------------
interface clock_tick_gen_if #(
  parameter int CH_W  = 1,
  parameter int CNT_W = 32
);

  logic             cfg_valid;
  logic             cfg_ready;
  logic [CH_W-1:0]  cfg_ch;
  logic [CNT_W-1:0] cfg_half;

  modport master (
    output cfg_valid,
    output cfg_ch,
    output cfg_half,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid,
    input  cfg_ch,
    input  cfg_half,
    output cfg_ready
  );

endinterface

// File: rtl/clock_tick_channel.sv
// ---------------------------------------------------------------------------
// clock_tick_channel
// One square-wave/tick channel with run, glitch-free stop and single-step.
//   clk_50MHz  in   clock
//   reset_n    in   synchronous active-low reset
//   run_en     in   level: free-run while high (sampled in STOP and at boundaries)
//   step       in   pulse: one full period, only honoured in STOP
//   apply      in   load new_half (in STOP, or at the boundary it coincides with)
//   new_half   in   half-period to load
//   clk_sq     out  registered square wave
//   tick       out  registered one-cycle pulse on each clk_sq rise
//   boundary   out  current phase ends at the coming edge
//   idle       out  channel is in STOP
// ---------------------------------------------------------------------------
module clock_tick_channel #(
  parameter int          CNT_W        = 32,
  parameter int unsigned DEFAULT_HALF = clock_tick_pkg::DEFAULT_HALF_CYC
) (
  input  logic             clk_50MHz,
  input  logic             reset_n,
  input  logic             run_en,
  input  logic             step,
  input  logic             apply,
  input  logic [CNT_W-1:0] new_half,
  output logic             clk_sq,
  output logic             tick,
  output logic             boundary,
  output logic             idle
);

  import clock_tick_pkg::*;

  ch_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] half_q, half_d;
  logic             sq_d;
  logic             tick_d;
  logic [CNT_W:0]   cnt_plus1;
  logic             at_limit;

  // Phase end is cnt >= half-1, evaluated one bit wider as cnt+1 >= half so
  // half-1 never underflows and a counter left above a shrunken half still
  // terminates on the next cycle instead of running to wrap-around.
  assign cnt_plus1 = {1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1};
  assign at_limit  = (cnt_plus1 >= {1'b0, half_q});

  assign idle     = (state_q == STOP);
  assign boundary = (state_q != STOP) && at_limit;

  // State, counter, half-period and both outputs are plain registers fed by
  // the next-state logic below.
  always_ff @(posedge clk_50MHz) begin
    if (!reset_n) begin
      state_q <= STOP;
      cnt_q   <= '0;
      half_q  <= CNT_W'(DEFAULT_HALF);
      clk_sq  <= 1'b0;
      tick    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      half_q  <= half_d;
      clk_sq  <= sq_d;
      tick    <= tick_d;
    end
  end

  // Next-state logic. Everything holds by default and tick is a pulse, so
  // it only goes high on the transitions that raise clk_sq.
  // A new half-period is only ever taken while idle or exactly at a phase
  // boundary, so a phase in progress always finishes with its old length.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    half_d  = half_q;
    sq_d    = clk_sq;
    tick_d  = 1'b0;

    if (state_q == STOP) begin
      cnt_d = '0;
      sq_d  = 1'b0;
      if (apply) begin
        half_d = new_half;
      end
      // run_en has priority over step; a zero half-period keeps the
      // channel parked.
      if (half_q != '0) begin
        if (run_en) begin
          state_d = RUN;
          sq_d    = 1'b1;
          tick_d  = 1'b1;
        end else if (step) begin
          state_d = STEP_HI;
          sq_d    = 1'b1;
          tick_d  = 1'b1;
        end
      end
    end else if (!at_limit) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = '0;
      if (apply) begin
        half_d = new_half;
      end
      if (apply && (new_half == '0)) begin
        state_d = STOP;
        sq_d    = 1'b0;
      end else begin
        case (state_q)
          RUN: begin
            // High phases always run to completion; run_en is only looked
            // at here, so dropping it can never shorten a high pulse.
            if (clk_sq) begin
              sq_d = 1'b0;
              if (!run_en) begin
                state_d = STOP;
              end
            end else if (run_en) begin
              sq_d   = 1'b1;
              tick_d = 1'b1;
            end else begin
              state_d = STOP;
            end
          end
          STEP_HI: begin
            state_d = STEP_LO;
            sq_d    = 1'b0;
          end
          default: begin
            state_d = STOP;
            sq_d    = 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/clock_tick_gen.sv
// ---------------------------------------------------------------------------
// clock_tick_gen
// Multi-channel, runtime-programmable square-wave and tick generator.
//   clk_50MHz  in   sole clock
//   reset_n    in   synchronous active-low reset
//   cfg        slave modport of clock_tick_gen_if (half-period updates)
//   run_en     in   [NUM_CH] per-channel free-run level
//   step       in   [NUM_CH] per-channel single-period request
//   clk_sq     out  [NUM_CH] registered 50% duty square waves
//   tick       out  [NUM_CH] one-cycle pulses coincident with clk_sq rises
// A single pending slot holds one accepted update until its target channel
// can take it (immediately when stopped, otherwise at its next boundary).
// ---------------------------------------------------------------------------
module clock_tick_gen #(
  parameter  int          NUM_CH       = 2,
  parameter  int          CNT_W        = 32,
  parameter  int unsigned DEFAULT_HALF = clock_tick_pkg::DEFAULT_HALF_CYC,
  localparam int          CH_W         = clock_tick_pkg::ch_width(NUM_CH)
) (
  input  logic              clk_50MHz,
  input  logic              reset_n,
  clock_tick_gen_if.slave   cfg,
  input  logic [NUM_CH-1:0] run_en,
  input  logic [NUM_CH-1:0] step,
  output logic [NUM_CH-1:0] clk_sq,
  output logic [NUM_CH-1:0] tick
);

  import clock_tick_pkg::*;

  logic              pend_valid;
  logic [CH_W-1:0]   pend_ch;
  logic [CNT_W-1:0]  pend_half;
  logic              pend_discard;
  logic              pend_done;
  logic [NUM_CH-1:0] apply_vec;
  logic [NUM_CH-1:0] bound_vec;
  logic [NUM_CH-1:0] idle_vec;

  // The slot is the only buffering, so ready is simply "slot empty".
  assign cfg.cfg_ready = ~pend_valid;

  // Updates aimed at a channel that does not exist are accepted and then
  // dropped one cycle later. When NUM_CH fills the select range no such
  // index can occur.
  if (NUM_CH == (2 ** CH_W)) begin : g_no_discard
    assign pend_discard = 1'b0;
  end else begin : g_discard
    assign pend_discard = pend_valid && (pend_ch >= CH_W'(NUM_CH));
  end

  assign pend_done = pend_discard || (|apply_vec);

  // Pending slot: captures a request when empty, frees itself on the edge
  // that delivers the value to its channel. Capturing only while empty means
  // a request accepted on a boundary edge waits for the following boundary.
  always_ff @(posedge clk_50MHz) begin
    if (!reset_n) begin
      pend_valid <= 1'b0;
      pend_ch    <= '0;
      pend_half  <= '0;
    end else if (pend_valid) begin
      if (pend_done) begin
        pend_valid <= 1'b0;
      end
    end else if (cfg.cfg_valid) begin
      pend_valid <= 1'b1;
      pend_ch    <= cfg.cfg_ch;
      pend_half  <= cfg.cfg_half;
    end
  end

  // One channel per output bit; each one takes the pending value only when
  // it is idle or sitting on a phase boundary.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign apply_vec[i] = pend_valid && (pend_ch == CH_W'(i)) &&
                          (idle_vec[i] || bound_vec[i]);

    clock_tick_channel #(
      .CNT_W        (CNT_W),
      .DEFAULT_HALF (DEFAULT_HALF)
    ) u_ch (
      .clk_50MHz (clk_50MHz),
      .reset_n   (reset_n),
      .run_en    (run_en[i]),
      .step      (step[i]),
      .apply     (apply_vec[i]),
      .new_half  (pend_half),
      .clk_sq    (clk_sq[i]),
      .tick      (tick[i]),
      .boundary  (bound_vec[i]),
      .idle      (idle_vec[i])
    );
  end

endmodule

// File: tb/tb_clock_tick_gen.sv
// ---------------------------------------------------------------------------
// tb_clock_tick_gen
// Directed bench for clock_tick_gen with NUM_CH=2 and DEFAULT_HALF=3.
// Inputs change on the falling edge and outputs are observed there too, so
// each observation shows the state registered by the preceding rising edge.
// ---------------------------------------------------------------------------
module tb_clock_tick_gen;

  localparam int NUM_CH       = 2;
  localparam int CNT_W        = 16;
  localparam int DEFAULT_HALF = 3;
  localparam int CH_W         = 1;

  logic              clk_50MHz = 1'b0;
  logic              reset_n;
  logic [NUM_CH-1:0] run_en;
  logic [NUM_CH-1:0] step;
  logic [NUM_CH-1:0] clk_sq;
  logic [NUM_CH-1:0] tick;

  int checks = 0;
  int errors = 0;

  logic [1:0] esq;
  logic [1:0] etk;
  logic       erdy;

  clock_tick_gen_if #(.CH_W(CH_W), .CNT_W(CNT_W)) cfg_if ();

  clock_tick_gen #(
    .NUM_CH       (NUM_CH),
    .CNT_W        (CNT_W),
    .DEFAULT_HALF (DEFAULT_HALF)
  ) dut (
    .clk_50MHz (clk_50MHz),
    .reset_n   (reset_n),
    .cfg       (cfg_if.slave),
    .run_en    (run_en),
    .step      (step),
    .clk_sq    (clk_sq),
    .tick      (tick)
  );

  // 50 MHz clock
  always #10 clk_50MHz = ~clk_50MHz;

  task automatic nextCycle();
    @(negedge clk_50MHz);
  endtask

  task automatic applyStimulus(input logic       rst_n,
                               input logic [1:0] run,
                               input logic [1:0] stp,
                               input logic       valid,
                               input logic       ch,
                               input logic [CNT_W-1:0] half);
    reset_n          = rst_n;
    run_en           = run;
    step             = stp;
    cfg_if.cfg_valid = valid;
    cfg_if.cfg_ch    = ch;
    cfg_if.cfg_half  = half;
  endtask

  task automatic checkOutput(input string tag, input logic [1:0] exp_sq,
                             input logic [1:0] exp_tick);
    checks++;
    assert ({clk_sq, tick} === {exp_sq, exp_tick}) else begin
      errors++;
      $error("[TB] FAIL %s: clk_sq=%b tick=%b, expected clk_sq=%b tick=%b",
             tag, clk_sq, tick, exp_sq, exp_tick);
    end
  endtask

  task automatic checkReady(input string tag, input logic exp_rdy);
    checks++;
    assert (cfg_if.cfg_ready === exp_rdy) else begin
      errors++;
      $error("[TB] FAIL %s: cfg_ready=%b, expected %b",
             tag, cfg_if.cfg_ready, exp_rdy);
    end
  endtask

  initial begin
    // Reset, then release
    applyStimulus(1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 16'd0);
    repeat (2) nextCycle();
    checkOutput("reset", 2'b00, 2'b00);
    checkReady("reset ready", 1'b1);
    applyStimulus(1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 16'd0);
    nextCycle();
    checkOutput("released", 2'b00, 2'b00);
    checkReady("released ready", 1'b1);

    // Free run ch0 with half=3: ticks at cycles 1,7,13
    $display("[TB] free run ch0");
    applyStimulus(1'b1, 2'b01, 2'b00, 1'b0, 1'b0, 16'd0);
    for (int k = 1; k <= 13; k++) begin
      nextCycle();
      esq = {1'b0, ((k - 1) % 6) < 3};
      etk = {1'b0, ((k - 1) % 6) == 0};
      checkOutput($sformatf("run c%0d", k), esq, etk);
    end

    // Update to half=5 accepted while cnt=1; current high phase keeps half=3
    $display("[TB] cfg update while running");
    nextCycle();
    checkOutput("upd c14", 2'b01, 2'b00);
    checkReady("upd ready c14", 1'b1);
    applyStimulus(1'b1, 2'b01, 2'b00, 1'b1, 1'b0, 16'd5);
    nextCycle();
    checkOutput("upd c15", 2'b01, 2'b00);
    checkReady("upd ready c15", 1'b0);
    applyStimulus(1'b1, 2'b01, 2'b00, 1'b0, 1'b0, 16'd0);
    for (int o = 1; o <= 16; o++) begin
      nextCycle();
      esq = {1'b0, ((o - 1) % 10) >= 5};
      etk = {1'b0, ((o - 1) % 10) == 5};
      checkOutput($sformatf("half5 c%0d", 15 + o), esq, etk);
      if (o == 1) checkReady("upd ready c16", 1'b1);
    end

    // Back to half=3, applied at the end of the current 5-cycle high phase
    applyStimulus(1'b1, 2'b01, 2'b00, 1'b1, 1'b0, 16'd3);
    nextCycle();
    checkOutput("back3 c32", 2'b01, 2'b00);
    checkReady("back3 ready c32", 1'b0);
    applyStimulus(1'b1, 2'b01, 2'b00, 1'b0, 1'b0, 16'd0);
    for (int c = 33; c <= 39; c++) begin
      nextCycle();
      esq  = {1'b0, (c <= 35) || (c == 39)};
      etk  = {1'b0, c == 39};
      erdy = (c >= 36);
      checkOutput($sformatf("back3 c%0d", c), esq, etk);
      checkReady($sformatf("back3 ready c%0d", c), erdy);
    end

    // Drop run_en right after a rise: high phase completes, then stop
    $display("[TB] glitch-free stop");
    applyStimulus(1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 16'd0);
    for (int c = 40; c <= 47; c++) begin
      nextCycle();
      esq = {1'b0, c <= 41};
      checkOutput($sformatf("stop c%0d", c), esq, 2'b00);
    end

    // Program half=2 into stopped ch0: ready back two cycles later
    applyStimulus(1'b1, 2'b00, 2'b00, 1'b1, 1'b0, 16'd2);
    nextCycle();
    checkReady("idle cfg ready low", 1'b0);
    applyStimulus(1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 16'd0);
    nextCycle();
    checkReady("idle cfg ready back", 1'b1);
    checkOutput("idle cfg out", 2'b00, 2'b00);

    // Single step: one tick, high 2, low 2, back to STOP
    $display("[TB] single step");
    applyStimulus(1'b1, 2'b00, 2'b01, 1'b0, 1'b0, 16'd0);
    nextCycle();
    checkOutput("step s0", 2'b01, 2'b01);
    applyStimulus(1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 16'd0);
    for (int o = 1; o <= 7; o++) begin
      nextCycle();
      esq = {1'b0, o == 1};
      checkOutput($sformatf("step s%0d", o), esq, 2'b00);
    end

    // step+run_en together acts as run; step held during RUN is ignored
    $display("[TB] run wins over step");
    applyStimulus(1'b1, 2'b01, 2'b01, 1'b0, 1'b0, 16'd0);
    for (int o = 0; o <= 8; o++) begin
      nextCycle();
      esq = {1'b0, (o % 4) < 2};
      etk = {1'b0, (o % 4) == 0};
      checkOutput($sformatf("runstep r%0d", o), esq, etk);
    end
    applyStimulus(1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 16'd0);
    nextCycle();
    checkOutput("runstep r9", 2'b01, 2'b00);
    for (int o = 10; o <= 12; o++) begin
      nextCycle();
      checkOutput($sformatf("runstep r%0d", o), 2'b00, 2'b00);
    end

    // half=0 to running ch1: stops at next boundary and stays stopped
    $display("[TB] disable running ch1");
    applyStimulus(1'b1, 2'b10, 2'b00, 1'b0, 1'b0, 16'd0);
    nextCycle();
    checkOutput("dis m1", 2'b10, 2'b10);
    applyStimulus(1'b1, 2'b10, 2'b00, 1'b1, 1'b1, 16'd0);
    nextCycle();
    checkOutput("dis m2", 2'b10, 2'b00);
    checkReady("dis ready m2", 1'b0);
    applyStimulus(1'b1, 2'b10, 2'b00, 1'b0, 1'b0, 16'd0);
    nextCycle();
    checkOutput("dis m3", 2'b10, 2'b00);
    for (int m = 4; m <= 10; m++) begin
      nextCycle();
      checkOutput($sformatf("dis m%0d", m), 2'b00, 2'b00);
      if (m == 4) checkReady("dis ready m4", 1'b1);
    end

    // Re-enable ch1 with half=3 while run_en held: starts once half is loaded
    applyStimulus(1'b1, 2'b10, 2'b00, 1'b1, 1'b1, 16'd3);
    nextCycle();
    checkReady("reen ready m11", 1'b0);
    checkOutput("reen m11", 2'b00, 2'b00);
    applyStimulus(1'b1, 2'b10, 2'b00, 1'b0, 1'b0, 16'd0);
    nextCycle();
    checkReady("reen ready m12", 1'b1);
    checkOutput("reen m12", 2'b00, 2'b00);
    nextCycle();
    checkOutput("reen m13", 2'b10, 2'b10);

    // Reset mid-high-phase with a pending half=7 update
    $display("[TB] reset with pending cfg");
    applyStimulus(1'b1, 2'b10, 2'b00, 1'b1, 1'b1, 16'd7);
    nextCycle();
    checkReady("rst pend ready", 1'b0);
    checkOutput("rst pend out", 2'b10, 2'b00);
    applyStimulus(1'b0, 2'b10, 2'b00, 1'b0, 1'b0, 16'd0);
    nextCycle();
    checkOutput("rst out", 2'b00, 2'b00);
    checkReady("rst ready", 1'b1);
    applyStimulus(1'b1, 2'b10, 2'b00, 1'b0, 1'b0, 16'd0);
    for (int o = 0; o <= 6; o++) begin
      nextCycle();
      esq = {((o % 6) < 3), 1'b0};
      etk = {((o % 6) == 0), 1'b0};
      checkOutput($sformatf("post rst o%0d", o), esq, etk);
      if (o == 0) checkReady("post rst ready", 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
